zl_rs_encoder: RTL and testbench
================================

ZL_RS_ENCODER -- requirements
Module: zl_rs_encoder

Interface
REQ-001 clk  input  1  rising-edge clock for all state.
REQ-002 rst_n  input  1  reset; asynchronous, active-low.
REQ-003 data_in_req  input  1  upstream byte valid.
REQ-004 data_in_ack  output  1  byte accepted; transfer when data_in_req && data_in_ack.
REQ-005 data_in  input  8  input byte, MSB first bit order irrelevant (byte symbols).
REQ-006 data_out_req  output  1  output byte valid (feeds the interleaver input).
REQ-007 data_out_ack  input  1  downstream accepts; transfer when data_out_req && data_out_ack.
REQ-008 data_out  output  8  output byte.
REQ-009 pkt_start  output  1  high while data_out holds byte 0 of a 204-byte codeword.

Function
REQ-010 Block SHALL implement the DVB shortened RS(204,188,T=8) encoder: 188 message bytes in, the same 188 bytes out unchanged, then 16 parity bytes.
REQ-011 GF(256) field polynomial SHALL be x^8+x^4+x^3+x^2+1; generator g(x)=prod_{i=0..15}(x+a^i), a=0x02.
REQ-012 Parity SHALL be computed by a 16-byte LFSR: fb = data_in XOR p[15]; p[k] <= p[k-1] XOR g_k*fb; p[0] <= g_0*fb; updated only on input transfer.
REQ-013 States: IDLE_DATA (awaiting/accepting message bytes), PARITY (emitting 16 parity bytes); no other states.
REQ-014 In IDLE_DATA, data_in_ack SHALL be (!data_out_req || data_out_ack); one-deep registered output stage, in->out latency exactly 1 cycle.
REQ-015 byte_cnt (0..187) SHALL count accepted message bytes; the transfer at byte_cnt==187 moves state to PARITY.
REQ-016 LFSR SHALL be treated as all-zero for byte_cnt==0 (feedback from zero, not from previous packet's residue).
REQ-017 In PARITY, data_in_ack SHALL be 0; p[15] presented first, register shifts one byte per output transfer; after the 16th parity transfer state returns to IDLE_DATA.
REQ-018 Full throughput SHALL be sustained: one byte per cycle with data_out_ack held high, 204 output cycles per 188 input bytes.
REQ-019 data_out_req SHALL drop only when the output register drains with no new byte loaded; data_out SHALL be stable while data_out_req && !data_out_ack.
REQ-020 pkt_start SHALL be high exactly with the first output byte of each codeword.

Reset
REQ-021 On rst_n low: state=IDLE_DATA, byte_cnt=0, parity register=0, data_out_req=0, data_out=0, pkt_start=0, data_in_ack=1 combinationally after reset.
REQ-022 Reset mid-packet SHALL discard the partial codeword; the first byte after reset starts a new packet.

Configuration
REQ-023 Macro ZL_RS_ENCODER_SYNC_CHECK_EN defined: at byte_cnt==0, an input byte other than 0x47 or 0xB8 SHALL be acked and dropped (no output, byte_cnt stays 0).
REQ-024 Macro undefined: any byte at byte_cnt==0 starts a packet; no sync comparison logic present.

Verification
REQ-025 188 zero bytes (sync check off), continuous ack -> 188 zero bytes then 16 bytes 0x00, pkt_start on output byte 0 only.
REQ-026 187 zero bytes then 0x01 (sync check off) -> parity 3B 0D 68 BD 44 D1 1E 08 A3 41 29 E5 62 32 24 3B in order.
REQ-027 Random data_out_ack (50%) over 10 packets -> output stream byte-identical to the continuous-ack run; data_out never changes while stalled.
REQ-028 Assert rst_n after byte 100 of a packet, then send a full packet -> exactly 204 output bytes, parity matches golden model for the new packet only.
REQ-029 With ZL_RS_ENCODER_SYNC_CHECK_EN: bytes 0x00,0x12 then 0x47+187 bytes -> two bytes dropped, one 204-byte codeword starting 0x47; 0xB8 lead byte also accepted.
REQ-030 Back-to-back packets, continuous req/ack -> data_in_ack low exactly 16 cycles per packet, no gap in data_out_req.

Source files
------------

// File: rtl/zl_rs_encoder_if.sv
// Byte-stream handshake bundle for the RS(204,188) encoder: message bytes in, codeword
// bytes out. The encoder uses the slave modport, its environment the master modport.
interface zl_rs_encoder_if;
  logic       data_in_req;
  logic       data_in_ack;
  logic [7:0] data_in;
  logic       data_out_req;
  logic       data_out_ack;
  logic [7:0] data_out;
  logic       pkt_start;

  modport master (
    output data_in_req, data_in, data_out_ack,
    input  data_in_ack, data_out_req, data_out, pkt_start
  );

  modport slave (
    input  data_in_req, data_in, data_out_ack,
    output data_in_ack, data_out_req, data_out, pkt_start
  );
endinterface

// File: rtl/zl_rs_encoder.sv
// DVB shortened RS(204,188,T=8) systematic encoder with a one-deep registered output stage.
// Optional ZL_RS_ENCODER_SYNC_CHECK_EN: drop lead bytes other than 0x47/0xB8.
module zl_rs_encoder (
  input logic            clk,
  input logic            rst_n,
  zl_rs_encoder_if.slave bus_io
);
  localparam int unsigned ParLen = 16;

  // g_k coefficients of prod_{i=0..15}(x + a^i) over GF(256), poly 0x11D; index k = x^k.
  localparam logic [7:0] GenCoef [ParLen] = '{
    8'h3B, 8'h24, 8'h32, 8'h62, 8'hE5, 8'h29, 8'h41, 8'hA3,
    8'h08, 8'h1E, 8'hD1, 8'h44, 8'hBD, 8'h68, 8'h0D, 8'h3B
  };

  typedef enum logic [0:0] {StIdleData, StParity} state_e;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] sh;
    acc = '0;
    sh  = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc ^= sh;
      sh = {sh[6:0], 1'b0} ^ (sh[7] ? 8'h1D : 8'h00);
    end
    return acc;
  endfunction

  state_e                    state_q, state_d;
  logic [7:0]                byte_cnt_q, byte_cnt_d;
  logic [3:0]                par_cnt_q, par_cnt_d;
  logic [ParLen-1:0][7:0]    par_q, par_d;
  logic                      out_valid_q, out_valid_d;
  logic [7:0]                out_data_q, out_data_d;
  logic                      sop_q, sop_d;

  logic       in_ack;
  logic       slot_free;
  logic       first;
  logic       sync_ok;
  logic [7:0] fb;

  assign first = (byte_cnt_q == 8'd0);

`ifdef ZL_RS_ENCODER_SYNC_CHECK_EN
  assign sync_ok = !first || (bus_io.data_in == 8'h47) || (bus_io.data_in == 8'hB8);
`else
  assign sync_ok = 1'b1;
`endif

  always_comb begin
    state_d     = state_q;
    byte_cnt_d  = byte_cnt_q;
    par_cnt_d   = par_cnt_q;
    par_d       = par_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    sop_d       = sop_q;
    in_ack      = 1'b0;
    fb          = 8'h00;
    slot_free   = !out_valid_q || bus_io.data_out_ack;

    if (out_valid_q && bus_io.data_out_ack) out_valid_d = 1'b0;

    unique case (state_q)
      StIdleData: begin
        in_ack = slot_free;
        if (bus_io.data_in_req && in_ack && sync_ok) begin
          // Start of a packet ignores any residue left in the parity register.
          fb       = bus_io.data_in ^ (first ? 8'h00 : par_q[ParLen-1]);
          par_d[0] = gf_mul(GenCoef[0], fb);
          for (int k = 1; k < ParLen; k++) begin
            par_d[k] = (first ? 8'h00 : par_q[k-1]) ^ gf_mul(GenCoef[k], fb);
          end
          out_valid_d = 1'b1;
          out_data_d  = bus_io.data_in;
          sop_d       = first;
          if (byte_cnt_q == 8'd187) begin
            byte_cnt_d = 8'd0;
            state_d    = StParity;
          end else begin
            byte_cnt_d = byte_cnt_q + 8'd1;
          end
        end
      end
      StParity: begin
        if (slot_free) begin
          out_valid_d = 1'b1;
          out_data_d  = par_q[ParLen-1];
          sop_d       = 1'b0;
          par_d       = {par_q[ParLen-2:0], 8'h00};
          if (par_cnt_q == 4'd15) begin
            par_cnt_d = 4'd0;
            state_d   = StIdleData;
          end else begin
            par_cnt_d = par_cnt_q + 4'd1;
          end
        end
      end
      default: state_d = StIdleData;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdleData;
      byte_cnt_q  <= 8'd0;
      par_cnt_q   <= 4'd0;
      par_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= 8'h00;
      sop_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      byte_cnt_q  <= byte_cnt_d;
      par_cnt_q   <= par_cnt_d;
      par_q       <= par_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      sop_q       <= sop_d;
    end
  end

  assign bus_io.data_in_ack  = in_ack;
  assign bus_io.data_out_req = out_valid_q;
  assign bus_io.data_out     = out_data_q;
  assign bus_io.pkt_start    = sop_q;
endmodule

// File: tb/tb_zl_rs_encoder.sv
// Randomized self-checking bench for zl_rs_encoder; expected codewords come from a
// polynomial long-division model with the generator built from its roots a^0..a^15.
module tb_zl_rs_encoder;
  localparam int MsgLen = 188;
  localparam int CwLen  = 204;
  typedef logic [7:0] msg_t [MsgLen];
  typedef logic [7:0] cw_t [CwLen];

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  zl_rs_encoder_if bus ();
  zl_rs_encoder dut (.clk(clk), .rst_n(rst_n), .bus_io(bus));

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] gen [17];
  logic [7:0] out_q [$];
  logic       sop_q [$];
  logic [7:0] exp_q [$];
  msg_t       pkts [10];

  logic       ack_random = 1'b0;
  logic       stall_prev = 1'b0;
  logic [7:0] stall_data = 8'h00;
  logic       stall_sop  = 1'b0;
  int         stall_seen = 0;
  int         stall_err  = 0;
  logic       measure    = 1'b0;
  int         gap_target = 0;
  int         ack_low_cnt = 0;
  int         gap_cnt    = 0;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    int x = int'(a);
    int y = int'(b);
    int p = 0;
    while (y != 0) begin
      if (y % 2 == 1) p = p ^ x;
      x = x * 2;
      if (x >= 256) x = x ^ 'h11D;
      y = y / 2;
    end
    return 8'(p);
  endfunction

  function automatic void encode(input msg_t m, output cw_t cw);
    logic [7:0] r [CwLen];
    logic [7:0] coef;
    for (int i = 0; i < CwLen; i++) r[i] = (i < MsgLen) ? m[i] : 8'h00;
    for (int i = 0; i < MsgLen; i++) begin
      coef = r[i];
      for (int j = 0; j <= 16; j++) r[i+j] = r[i+j] ^ gf_mul(coef, gen[16-j]);
    end
    for (int i = 0; i < CwLen; i++) cw[i] = (i < MsgLen) ? m[i] : r[i];
  endfunction

  function automatic int first_diff();
    int n = (out_q.size() < exp_q.size()) ? out_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) if (out_q[i] !== exp_q[i]) return i;
    if (out_q.size() != exp_q.size()) return n;
    return -1;
  endfunction

  function automatic int sop_diff();
    for (int i = 0; i < sop_q.size(); i++) if (sop_q[i] !== (i % CwLen == 0)) return i;
    return -1;
  endfunction

  // Output monitor: sampled on the falling edge, between driver updates and active edges.
  always @(negedge clk) begin
    if (!rst_n) begin
      stall_prev <= 1'b0;
    end else begin
      if (stall_prev) begin
        stall_seen <= stall_seen + 1;
        if (!bus.data_out_req || bus.data_out !== stall_data || bus.pkt_start !== stall_sop)
          stall_err <= stall_err + 1;
      end
      if (bus.data_out_req && bus.data_out_ack) begin
        out_q.push_back(bus.data_out);
        sop_q.push_back(bus.pkt_start);
      end
      stall_prev <= bus.data_out_req && !bus.data_out_ack;
      stall_data <= bus.data_out;
      stall_sop  <= bus.pkt_start;
      if (measure) begin
        if (!bus.data_in_ack) ack_low_cnt <= ack_low_cnt + 1;
        if (!bus.data_out_req && out_q.size() > 0 && out_q.size() < gap_target)
          gap_cnt <= gap_cnt + 1;
      end
    end
  end

  initial begin
    bus.data_out_ack = 1'b1;
    forever begin
      @(posedge clk);
      #1 bus.data_out_ack = ack_random ? ($urandom_range(0, 1) == 1) : 1'b1;
    end
  end

  task automatic clear_q();
    out_q.delete();
    sop_q.delete();
    exp_q.delete();
  endtask

  task automatic rand_msg(output msg_t m);
    for (int i = 0; i < MsgLen; i++) m[i] = 8'($urandom_range(0, 255));
`ifdef ZL_RS_ENCODER_SYNC_CHECK_EN
    m[0] = ($urandom_range(0, 1) == 1) ? 8'h47 : 8'hB8;
`endif
  endtask

  task automatic drive_byte(input logic [7:0] b);
    int guard = 0;
    bus.data_in_req = 1'b1;
    bus.data_in     = b;
    @(negedge clk);
    while (!bus.data_in_ack && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    n_checks++;
    if (guard >= 2000) begin
      n_fail++;
      $display("FAIL input_ack_timeout: waited %0d cycles, required ack within 2000", guard);
    end
    @(posedge clk);
    #1 bus.data_in_req = 1'b0;
  endtask

  task automatic send_packet(input msg_t m, input logic gaps);
    cw_t cw;
    encode(m, cw);
    for (int i = 0; i < CwLen; i++) exp_q.push_back(cw[i]);
    for (int i = 0; i < MsgLen; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
      drive_byte(m[i]);
    end
  endtask

  task automatic wait_out(input int n, input string name);
    int guard = 0;
    while (out_q.size() < n && guard < 20000) begin
      @(posedge clk);
      #1;
      guard++;
    end
    repeat (20) begin
      @(posedge clk);
      #1;
    end
    n_checks++;
    if (out_q.size() != n) begin
      n_fail++;
      $display("FAIL %s_count: got %0d bytes, required %0d", name, out_q.size(), n);
    end
  endtask

  task automatic check_stream(input string name);
    int d = first_diff();
    int s = sop_diff();
    n_checks++;
    if (d >= 0) begin
      n_fail++;
      $display("FAIL %s_data: byte %0d got %h required %h", name, d,
               (d < out_q.size()) ? out_q[d] : 8'hxx, (d < exp_q.size()) ? exp_q[d] : 8'hxx);
    end
    n_checks++;
    if (s >= 0) begin
      n_fail++;
      $display("FAIL %s_pkt_start: byte %0d got %b required %b", name, s, sop_q[s],
               (s % CwLen == 0));
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.data_in_req = 1'b0;
    bus.data_in = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (bus.data_in_ack !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_in_ack: got %b required 1", bus.data_in_ack);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if (bus.data_out_req !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_out_req: got %b required 0", bus.data_out_req);
    end
    n_checks++;
    if (bus.data_out !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_out_data: got %h required 00", bus.data_out);
    end
    n_checks++;
    if (bus.pkt_start !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_pkt_start: got %b required 0", bus.pkt_start);
    end
    n_checks++;
    if (bus.data_in_ack !== 1'b1) begin
      n_fail++;
      $display("FAIL post_reset_in_ack: got %b required 1", bus.data_in_ack);
    end
  endtask

  task automatic test_zero_packet();
    msg_t m;
    int nz = 0;
    clear_q();
    for (int i = 0; i < MsgLen; i++) m[i] = 8'h00;
    send_packet(m, 1'b0);
    wait_out(CwLen, "zero");
    foreach (out_q[i]) if (out_q[i] !== 8'h00) nz++;
    n_checks++;
    if (nz != 0) begin
      n_fail++;
      $display("FAIL zero_all_bytes: got %0d nonzero bytes, required 0", nz);
    end
    check_stream("zero");
  endtask

  task automatic test_golden_parity();
    msg_t m;
    logic [7:0] golden [16] = '{8'h3B, 8'h0D, 8'h68, 8'hBD, 8'h44, 8'hD1, 8'h1E, 8'h08,
                               8'hA3, 8'h41, 8'h29, 8'hE5, 8'h62, 8'h32, 8'h24, 8'h3B};
    int bad = -1;
    clear_q();
    for (int i = 0; i < MsgLen; i++) m[i] = 8'h00;
    m[MsgLen-1] = 8'h01;
    send_packet(m, 1'b0);
    wait_out(CwLen, "golden");
    for (int i = 15; i >= 0; i--)
      if (out_q.size() == CwLen && out_q[MsgLen+i] !== golden[i]) bad = i;
    n_checks++;
    if (bad >= 0 || out_q.size() != CwLen) begin
      n_fail++;
      $display("FAIL golden_parity: parity byte %0d got %h required %h", bad,
               (bad >= 0) ? out_q[MsgLen+bad] : 8'hxx, (bad >= 0) ? golden[bad] : 8'hxx);
    end
    check_stream("golden");
  endtask

  task automatic test_random_stall();
    logic [7:0] saved [$];
    clear_q();
    stall_seen = 0;
    stall_err  = 0;
    ack_random = 1'b1;
    for (int p = 0; p < 10; p++) begin
      rand_msg(pkts[p]);
      send_packet(pkts[p], 1'b1);
    end
    wait_out(10 * CwLen, "stall");
    ack_random = 1'b0;
    check_stream("stall");
    n_checks++;
    if (stall_err != 0) begin
      n_fail++;
      $display("FAIL stall_stable: got %0d changes while stalled, required 0", stall_err);
    end
    n_checks++;
    if (stall_seen == 0) begin
      n_fail++;
      $display("FAIL stall_exercised: got %0d stall cycles, required >0", stall_seen);
    end
    saved = out_q;
    clear_q();
    for (int p = 0; p < 10; p++) send_packet(pkts[p], 1'b0);
    wait_out(10 * CwLen, "rerun");
    exp_q = saved;
    check_stream("rerun_vs_stall");
  endtask

  task automatic test_reset_mid_packet();
    msg_t m;
    rand_msg(m);
    for (int i = 0; i <= 100; i++) drive_byte(m[i]);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus.data_out_req !== 1'b0 || bus.data_in_ack !== 1'b1) begin
      n_fail++;
      $display("FAIL midreset_outputs: got req %b ack %b required req 0 ack 1",
               bus.data_out_req, bus.data_in_ack);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    clear_q();
    rand_msg(m);
    send_packet(m, 1'b0);
    wait_out(CwLen, "midreset");
    check_stream("midreset");
  endtask

  task automatic test_back_to_back();
    msg_t m;
    clear_q();
    ack_low_cnt = 0;
    gap_cnt     = 0;
    gap_target  = 3 * CwLen;
    measure     = 1'b1;
    for (int p = 0; p < 3; p++) begin
      rand_msg(m);
      send_packet(m, 1'b0);
    end
    while (out_q.size() < 3 * CwLen && ack_low_cnt < 1000) begin
      @(posedge clk);
      #1;
    end
    measure = 1'b0;
    wait_out(3 * CwLen, "b2b");
    n_checks++;
    if (ack_low_cnt != 48) begin
      n_fail++;
      $display("FAIL b2b_ack_low: got %0d cycles, required 48", ack_low_cnt);
    end
    n_checks++;
    if (gap_cnt != 0) begin
      n_fail++;
      $display("FAIL b2b_out_gap: got %0d idle cycles, required 0", gap_cnt);
    end
    check_stream("b2b");
  endtask

`ifdef ZL_RS_ENCODER_SYNC_CHECK_EN
  task automatic test_lead_byte();
    msg_t m;
    clear_q();
    drive_byte(8'h00);
    drive_byte(8'h12);
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (out_q.size() != 0) begin
      n_fail++;
      $display("FAIL sync_drop: got %0d output bytes, required 0", out_q.size());
    end
    rand_msg(m);
    m[0] = 8'h47;
    send_packet(m, 1'b0);
    rand_msg(m);
    m[0] = 8'hB8;
    send_packet(m, 1'b0);
    wait_out(2 * CwLen, "sync");
    check_stream("sync");
  endtask
`else
  task automatic test_lead_byte();
    msg_t m;
    clear_q();
    rand_msg(m);
    m[0] = 8'h12;
    send_packet(m, 1'b0);
    wait_out(CwLen, "anylead");
    n_checks++;
    if (out_q.size() == 0 || out_q[0] !== 8'h12) begin
      n_fail++;
      $display("FAIL anylead_first: got %h required 12", (out_q.size() > 0) ? out_q[0] : 8'hxx);
    end
    check_stream("anylead");
  endtask
`endif

  initial begin
    logic [7:0] root;
    for (int k = 0; k < 17; k++) gen[k] = 8'h00;
    gen[0] = 8'h01;
    root = 8'h01;
    for (int i = 0; i < 16; i++) begin
      for (int k = 16; k > 0; k--) gen[k] = gen[k-1] ^ gf_mul(gen[k], root);
      gen[0] = gf_mul(gen[0], root);
      root = gf_mul(root, 8'h02);
    end
    test_reset();
`ifndef ZL_RS_ENCODER_SYNC_CHECK_EN
    test_zero_packet();
    test_golden_parity();
`endif
    test_random_stall();
    test_reset_mid_packet();
    test_back_to_back();
    test_lead_byte();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
